// File: rtl/elvm_pkg.sv
// Shared ELVM CPU definitions: opcode values, instruction field positions,
// and the fetch-stage state encoding.
package elvm_pkg;

  // Opcodes carried in the OP field
  localparam logic [4:0] OP_MOV   = 5'd0;
  localparam logic [4:0] OP_ADD   = 5'd1;
  localparam logic [4:0] OP_SUB   = 5'd2;
  localparam logic [4:0] OP_LOAD  = 5'd3;
  localparam logic [4:0] OP_STORE = 5'd4;
  localparam logic [4:0] OP_PUTC  = 5'd5;
  localparam logic [4:0] OP_GETC  = 5'd6;
  localparam logic [4:0] OP_EXIT  = 5'd7;
  localparam logic [4:0] OP_JEQ   = 5'd8;
  localparam logic [4:0] OP_JNE   = 5'd9;
  localparam logic [4:0] OP_JLT   = 5'd10;
  localparam logic [4:0] OP_JGT   = 5'd11;
  localparam logic [4:0] OP_JLE   = 5'd12;
  localparam logic [4:0] OP_JGE   = 5'd13;
  localparam logic [4:0] OP_JMP   = 5'd14;
  localparam logic [4:0] OP_EQ    = 5'd15;
  localparam logic [4:0] OP_NE    = 5'd16;
  localparam logic [4:0] OP_LT    = 5'd17;
  localparam logic [4:0] OP_GT    = 5'd18;
  localparam logic [4:0] OP_LE    = 5'd19;
  localparam logic [4:0] OP_GE    = 5'd20;
  localparam logic [4:0] OP_DUMP  = 5'd21;

  // Instruction field positions (26-bit word)
  localparam int unsigned IMM_SEL_BIT = 25;
  localparam int unsigned OP_MSB      = 24;
  localparam int unsigned OP_LSB      = 20;
  localparam int unsigned DST_MSB     = 19;
  localparam int unsigned DST_LSB     = 17;
  localparam int unsigned SRC_MSB     = 16;
  localparam int unsigned SRC_LSB     = 14;
  localparam int unsigned IMM_MSB     = 13;
  localparam int unsigned IMM_LSB     = 0;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    HALT  = 2'd2
  } fetch_state_t;

  // Extract the opcode field from an instruction word
  function automatic logic [4:0] op_of(input logic [25:0] inst);
    return inst[OP_MSB:OP_LSB];
  endfunction

endpackage

// File: rtl/fetch_buf.sv
// Two-entry shift FIFO of {pc, inst} used by the prefetching fetch stage.
// Ports: clk, rst (sync, active-high), flush (drop all entries), push/push_pc/
// push_inst (enqueue), pop (dequeue head), full, head_valid/head_pc/head_inst.
// Entry 0 is always the head so head outputs come straight from registers.
module fetch_buf #(
  parameter int unsigned AW = 8,
  parameter int unsigned IW = 26
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          push,
  input  logic [AW-1:0] push_pc,
  input  logic [IW-1:0] push_inst,
  input  logic          pop,
  output logic          full,
  output logic          head_valid,
  output logic [AW-1:0] head_pc,
  output logic [IW-1:0] head_inst
);

  logic          v0_q, v1_q, v0_d, v1_d;
  logic [AW-1:0] pc0_q, pc1_q, pc0_d, pc1_d;
  logic [IW-1:0] in0_q, in1_q, in0_d, in1_d;

  // Pop shifts entry 1 forward, push fills the first free slot, flush wins
  always_comb begin
    v0_d  = v0_q;
    v1_d  = v1_q;
    pc0_d = pc0_q;
    pc1_d = pc1_q;
    in0_d = in0_q;
    in1_d = in1_q;
    if (pop) begin
      v0_d  = v1_q;
      pc0_d = pc1_q;
      in0_d = in1_q;
      v1_d  = 1'b0;
    end
    if (push) begin
      if (!v0_d) begin
        v0_d  = 1'b1;
        pc0_d = push_pc;
        in0_d = push_inst;
      end else begin
        v1_d  = 1'b1;
        pc1_d = push_pc;
        in1_d = push_inst;
      end
    end
    if (flush) begin
      v0_d = 1'b0;
      v1_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v0_q  <= 1'b0;
      v1_q  <= 1'b0;
      pc0_q <= '0;
      pc1_q <= '0;
      in0_q <= '0;
      in1_q <= '0;
    end else begin
      v0_q  <= v0_d;
      v1_q  <= v1_d;
      pc0_q <= pc0_d;
      pc1_q <= pc1_d;
      in0_q <= in0_d;
      in1_q <= in1_d;
    end
  end

  assign full       = v1_q;
  assign head_valid = v0_q;
  assign head_pc    = pc0_q;
  assign head_inst  = in0_q;

endmodule

// File: rtl/inst_fetch.sv
// ELVM program-counter / instruction-fetch stage. Addresses a combinational
// instruction ROM, registers each word with its PC and offers it downstream
// over valid/ready. Handles jump redirects and a sticky halt.
// Ports: clk, rst (sync, active-high); rom_addr/rom_data (ROM side);
// out_valid/out_ready/out_inst/out_pc (downstream); redirect_valid/redirect_pc,
// halt_req (from execute); halted (sticky until rst).
// Build option FETCH_PREFETCH_EN: 2-entry buffer whose load decision depends
// only on registered occupancy (no out_ready -> pc path). Default: single
// output register loaded when !out_valid || out_ready.
module inst_fetch
  import elvm_pkg::*;
#(
  parameter int unsigned   AW       = 8,
  parameter int unsigned   IW       = 26,
  parameter logic [AW-1:0] RESET_PC = '0
) (
  input  logic          clk,
  input  logic          rst,
  output logic [AW-1:0] rom_addr,
  input  logic [IW-1:0] rom_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [IW-1:0] out_inst,
  output logic [AW-1:0] out_pc,
  input  logic          redirect_valid,
  input  logic [AW-1:0] redirect_pc,
  input  logic          halt_req,
  output logic          halted
);

  fetch_state_t  state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic          halted_q, halted_d;
  logic          run_c, redir_c, halt_c, xfer_c, room_c, load_c;

`ifdef FETCH_PREFETCH_EN
  logic buf_full;

  fetch_buf #(.AW(AW), .IW(IW)) u_buf (
    .clk        (clk),
    .rst        (rst),
    .flush      (redir_c || halt_c),
    .push       (load_c),
    .push_pc    (pc_q),
    .push_inst  (rom_data),
    .pop        (xfer_c),
    .full       (buf_full),
    .head_valid (out_valid),
    .head_pc    (out_pc),
    .head_inst  (out_inst)
  );
`else
  logic          vld_q, vld_d;
  logic [IW-1:0] inst_q, inst_d;
  logic [AW-1:0] opc_q, opc_d;

  // Output register: redirect/halt drop the word, load overwrites, transfer empties
  always_comb begin
    vld_d  = vld_q;
    inst_d = inst_q;
    opc_d  = opc_q;
    if (redir_c || halt_c) begin
      vld_d = 1'b0;
    end else if (load_c) begin
      vld_d  = 1'b1;
      inst_d = rom_data;
      opc_d  = pc_q;
    end else if (xfer_c) begin
      vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q  <= 1'b0;
      inst_q <= '0;
      opc_q  <= '0;
    end else begin
      vld_q  <= vld_d;
      inst_q <= inst_d;
      opc_q  <= opc_d;
    end
  end

  assign out_valid = vld_q;
  assign out_inst  = inst_q;
  assign out_pc    = opc_q;
`endif

  // Next state, PC and halt flag; redirect beats halt_req, HALT ignores both
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    halted_d = halted_q;
    run_c    = (state_q != HALT);
    redir_c  = run_c && redirect_valid;
    halt_c   = run_c && !redirect_valid && halt_req;
    xfer_c   = out_valid && out_ready;
`ifdef FETCH_PREFETCH_EN
    room_c   = !buf_full;
`else
    room_c   = !out_valid || out_ready;
`endif
    load_c   = run_c && !redirect_valid && !halt_req && room_c;

    if (redir_c) begin
      pc_d = redirect_pc;
    end else if (load_c) begin
      pc_d = pc_q + AW'(1);
    end

    if (halt_c) begin
      halted_d = 1'b1;
    end

    case (state_q)
      FETCH: begin
        if (halt_c)                     state_d = HALT;
        else if (load_c && !out_ready)  state_d = HOLD;
      end
      HOLD: begin
        if (halt_c)                     state_d = HALT;
        else if (redir_c || xfer_c)     state_d = FETCH;
      end
      HALT:    state_d = HALT;
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= FETCH;
      pc_q     <= RESET_PC;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      halted_q <= halted_d;
    end
  end

  assign rom_addr = pc_q;
  assign halted   = halted_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: directed vector table, then random traffic checked
// against a transaction-level model of the fetch stage.
module tb_inst_fetch;

  localparam int unsigned AW = 8;
  localparam int unsigned IW = 26;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] rom_addr;
  logic [IW-1:0] rom_data;
  logic          out_valid;
  logic          out_ready;
  logic [IW-1:0] out_inst;
  logic [AW-1:0] out_pc;
  logic          redirect_valid;
  logic [AW-1:0] redirect_pc;
  logic          halt_req;
  logic          halted;

  logic [IW-1:0] rom [256];

  always #5 clk = ~clk;

  assign rom_data = rom[rom_addr];

  inst_fetch #(.AW(AW), .IW(IW), .RESET_PC(8'h00)) dut (
    .clk            (clk),
    .rst            (rst),
    .rom_addr       (rom_addr),
    .rom_data       (rom_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_inst       (out_inst),
    .out_pc         (out_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt_req       (halt_req),
    .halted         (halted)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [IW-1:0] rom_word(input int unsigned a);
    return IW'(a * 32'h1357 + 32'h2A5);
  endfunction

  typedef struct {
    logic       rst;
    logic       rdy;
    logic       rdr;
    logic [7:0] rpc;
    logic       hr;
    logic       ev;
    logic [7:0] epc;
    logic [7:0] eaddr;
    logic       eh;
    logic       ezero;
  } vec_t;

  vec_t tv[$];

  task automatic add(input logic r, input logic rdy, input logic rdr, input logic [7:0] rpc,
                     input logic hr, input logic ev, input logic [7:0] epc,
                     input logic [7:0] eaddr, input logic eh, input logic ez);
    vec_t v;
    v.rst = r;  v.rdy = rdy; v.rdr = rdr; v.rpc = rpc; v.hr = hr;
    v.ev = ev;  v.epc = epc; v.eaddr = eaddr; v.eh = eh; v.ezero = ez;
    tv.push_back(v);
  endtask

  // Reference model state
  logic [AW-1:0] m_pc;
  logic          m_v;
  logic [IW-1:0] m_inst;
  logic [AW-1:0] m_opc;
  logic          m_h;

  task automatic model_step();
    if (rst) begin
      m_pc = 8'h00; m_v = 1'b0; m_inst = '0; m_opc = '0; m_h = 1'b0;
    end else if (m_h) begin
      m_v = 1'b0;
    end else if (redirect_valid) begin
      m_pc = redirect_pc; m_v = 1'b0;
    end else if (halt_req) begin
      m_v = 1'b0; m_h = 1'b1;
    end else if (!m_v || out_ready) begin
      m_inst = rom[m_pc];
      m_opc  = m_pc;
      m_v    = 1'b1;
      m_pc   = AW'((32'(m_pc) + 1) % 256);
    end
  endtask

  initial begin
    rst = 1'b1; out_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; halt_req = 1'b0;
    for (int i = 0; i < 256; i++) rom[i] = rom_word(i);

    //   rst rdy rdr rpc    hr  ev  epc    eaddr  eh  ez
    add(1, 0, 0, 8'h00, 0, 0, 8'h00, 8'h00, 0, 1);   // reset
    add(0, 1, 0, 8'h00, 0, 1, 8'h00, 8'h01, 0, 0);   // streaming A..D
    add(0, 1, 0, 8'h00, 0, 1, 8'h01, 8'h02, 0, 0);
    add(0, 1, 0, 8'h00, 0, 1, 8'h02, 8'h03, 0, 0);
    add(0, 1, 0, 8'h00, 0, 1, 8'h03, 8'h04, 0, 0);
    add(0, 1, 0, 8'h00, 0, 1, 8'h04, 8'h05, 0, 0);
    add(0, 1, 0, 8'h00, 0, 1, 8'h05, 8'h06, 0, 0);
    add(0, 0, 0, 8'h00, 0, 1, 8'h05, 8'h06, 0, 0);   // 3-cycle stall on word 5
    add(0, 0, 0, 8'h00, 0, 1, 8'h05, 8'h06, 0, 0);
    add(0, 0, 0, 8'h00, 0, 1, 8'h05, 8'h06, 0, 0);
    add(0, 1, 0, 8'h00, 0, 1, 8'h06, 8'h07, 0, 0);   // release: word 6
    add(0, 1, 0, 8'h00, 0, 1, 8'h07, 8'h08, 0, 0);
    add(0, 0, 0, 8'h00, 0, 1, 8'h07, 8'h08, 0, 0);   // word 7 held
    add(0, 0, 1, 8'h40, 0, 0, 8'h00, 8'h40, 0, 0);   // redirect drops word 7
    add(0, 1, 0, 8'h00, 0, 1, 8'h40, 8'h41, 0, 0);
    add(0, 1, 1, 8'hFE, 0, 0, 8'h00, 8'hFE, 0, 0);   // go to PC wrap
    add(0, 1, 0, 8'h00, 0, 1, 8'hFE, 8'hFF, 0, 0);
    add(0, 1, 0, 8'h00, 0, 1, 8'hFF, 8'h00, 0, 0);
    add(0, 1, 0, 8'h00, 0, 1, 8'h00, 8'h01, 0, 0);
    add(0, 1, 1, 8'h10, 1, 0, 8'h00, 8'h10, 0, 0);   // redirect beats halt
    add(0, 1, 0, 8'h00, 0, 1, 8'h10, 8'h11, 0, 0);
    add(0, 1, 0, 8'h00, 1, 0, 8'h00, 8'h11, 1, 0);   // halt with transfer
    add(0, 0, 1, 8'h80, 0, 0, 8'h00, 8'h11, 1, 0);   // redirect ignored
    add(0, 1, 0, 8'h00, 0, 0, 8'h00, 8'h11, 1, 0);
    add(1, 1, 0, 8'h00, 0, 0, 8'h00, 8'h00, 0, 1);   // rst exits HALT
    add(0, 0, 0, 8'h00, 0, 1, 8'h00, 8'h01, 0, 0);
    add(0, 0, 0, 8'h00, 0, 1, 8'h00, 8'h01, 0, 0);
    add(1, 0, 0, 8'h00, 0, 0, 8'h00, 8'h00, 0, 1);   // rst mid-handshake
    add(0, 1, 0, 8'h00, 0, 1, 8'h00, 8'h01, 0, 0);

    for (int i = 0; i < tv.size(); i++) begin
      rst = tv[i].rst; out_ready = tv[i].rdy; redirect_valid = tv[i].rdr;
      redirect_pc = tv[i].rpc; halt_req = tv[i].hr;
      @(negedge clk);
      check($sformatf("v%0d_valid", i), 32'(out_valid), 32'(tv[i].ev));
      check($sformatf("v%0d_rom_addr", i), 32'(rom_addr), 32'(tv[i].eaddr));
      check($sformatf("v%0d_halted", i), 32'(halted), 32'(tv[i].eh));
      if (tv[i].ev) begin
        check($sformatf("v%0d_out_pc", i), 32'(out_pc), 32'(tv[i].epc));
        check($sformatf("v%0d_out_inst", i), 32'(out_inst), 32'(rom_word(32'(tv[i].epc))));
      end
      if (tv[i].ezero) begin
        check($sformatf("v%0d_rst_pc", i), 32'(out_pc), 32'h0);
        check($sformatf("v%0d_rst_inst", i), 32'(out_inst), 32'h0);
      end
    end

    // Random traffic against the model
    for (int i = 0; i < 256; i++) rom[i] = IW'($urandom);
    m_pc = '0; m_v = 1'b0; m_inst = '0; m_opc = '0; m_h = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      rst            = (c == 0) || ($urandom_range(0, 199) == 0);
      out_ready      = ($urandom_range(0, 9) < 7);
      redirect_valid = ($urandom_range(0, 19) == 0);
      redirect_pc    = AW'($urandom);
      halt_req       = ($urandom_range(0, 39) == 0);
      @(posedge clk);
      model_step();
      @(negedge clk);
      check($sformatf("r%0d_valid", c), 32'(out_valid), 32'(m_v));
      check($sformatf("r%0d_rom_addr", c), 32'(rom_addr), 32'(m_pc));
      check($sformatf("r%0d_halted", c), 32'(halted), 32'(m_h));
      if (m_v) begin
        check($sformatf("r%0d_out_pc", c), 32'(out_pc), 32'(m_opc));
        check($sformatf("r%0d_out_inst", c), 32'(out_inst), 32'(m_inst));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
